// File: rtl/reset_sequencer.sv
// Board reset generator: holds every domain through a hold time, then releases them in index order.
// Define WATCHDOG_EN to build the optional watchdog restart.
//
// state   | meaning
// HOLD    | all domains in reset, hold counter running down
// RELEASE | domain resets dropping one per stage interval
// RUN     | all domains out of reset
module reset_sequencer #(
  parameter int unsigned FREQ            = 48_000_000,
  parameter int unsigned HOLD_CYCLES     = 48_000_000,
  parameter int unsigned STAGE_CYCLES    = 16,
  parameter int unsigned NUM_DOMAINS     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 480_000,
  parameter int unsigned WDT_CYCLES      = 2**24
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   button_n,
  input  logic                   clock_locked,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic [1:0]             state,
  output logic [1:0]             reset_cause,
  output logic [3:0]             progress
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned SW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAGE_LOAD = SW'(STAGE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LOAD   = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] CAUSE_RST    = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_LOCK   = 2'd2;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } seq_state_t;

  seq_state_t             state_q;
  logic [HW-1:0]          hold_cnt;
  logic [SW-1:0]          stage_cnt;
  logic [DW-1:0]          deb_cnt;
  logic                   pressed;
  logic                   btn_s1, btn_s2;
  logic                   lock_s1, lock_s2;
  logic                   btn_level;
  logic                   fault;
  logic [1:0]             fault_cause;
  logic [NUM_DOMAINS-1:0] dom_next;
  logic [3:0]             hold_top;

`ifdef WATCHDOG_EN
  localparam int unsigned   WW       = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WW-1:0] WDT_LOAD = WW'(WDT_CYCLES - 1);
  localparam logic [1:0]    CAUSE_WDT = 2'd3;

  logic [WW-1:0] wdt_cnt;
  logic          unused_cfg;
  assign unused_cfg = ^32'(FREQ);
`else
  logic unused_cfg;
  assign unused_cfg = ^{wdt_kick, 32'(FREQ), 32'(WDT_CYCLES)};
`endif

  // Synchronisers are deliberately not reset so they keep tracking the pins through rst.
  always_ff @(posedge clock) begin
    btn_s1  <= button_n;
    btn_s2  <= btn_s1;
    lock_s1 <= clock_locked;
    lock_s2 <= lock_s1;
  end

  assign btn_level = ~btn_s2;

  always_ff @(posedge clock) begin
    if (rst) begin
      pressed <= 1'b0;
      deb_cnt <= DEB_LOAD;
    end else if (btn_level == pressed) begin
      deb_cnt <= DEB_LOAD;
    end else if (deb_cnt == '0) begin
      pressed <= btn_level;
      deb_cnt <= DEB_LOAD;
    end else begin
      deb_cnt <= deb_cnt - DW'(1);
    end
  end

  always_comb begin
    fault       = 1'b0;
    fault_cause = CAUSE_RST;
    if (pressed) begin
      fault       = 1'b1;
      fault_cause = CAUSE_BUTTON;
    end else if (!lock_s2) begin
      fault       = 1'b1;
      fault_cause = CAUSE_LOCK;
    end
`ifdef WATCHDOG_EN
    else if (state_q == S_RUN && wdt_cnt == '0 && !wdt_kick) begin
      fault       = 1'b1;
      fault_cause = CAUSE_WDT;
    end
`endif
  end

  // Domains drop in ascending order, so each release step is a left shift of the mask.
  assign dom_next = domain_rst << 1;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_HOLD;
      domain_rst  <= '1;
      reset_cause <= CAUSE_RST;
      hold_cnt    <= HOLD_LOAD;
      stage_cnt   <= STAGE_LOAD;
`ifdef WATCHDOG_EN
      wdt_cnt     <= WDT_LOAD;
`endif
    end else if (fault) begin
      state_q     <= S_HOLD;
      domain_rst  <= '1;
      reset_cause <= fault_cause;
      hold_cnt    <= HOLD_LOAD;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_cnt == '0) begin
            domain_rst <= dom_next;
            stage_cnt  <= STAGE_LOAD;
            if (dom_next == '0) begin
              state_q <= S_RUN;
`ifdef WATCHDOG_EN
              wdt_cnt <= WDT_LOAD;
`endif
            end else begin
              state_q <= S_RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        S_RELEASE: begin
          if (stage_cnt == '0) begin
            domain_rst <= dom_next;
            stage_cnt  <= STAGE_LOAD;
            if (dom_next == '0) begin
              state_q <= S_RUN;
`ifdef WATCHDOG_EN
              wdt_cnt <= WDT_LOAD;
`endif
            end
          end else begin
            stage_cnt <= stage_cnt - SW'(1);
          end
        end
        S_RUN: begin
          domain_rst <= '0;
`ifdef WATCHDOG_EN
          if (wdt_kick) begin
            wdt_cnt <= WDT_LOAD;
          end else begin
            wdt_cnt <= wdt_cnt - WW'(1);
          end
`endif
        end
        default: begin
          state_q    <= S_HOLD;
          domain_rst <= '1;
          hold_cnt   <= HOLD_LOAD;
        end
      endcase
    end
  end

  generate
    if (HW >= 4) begin : g_prog_wide
      assign hold_top = hold_cnt[HW-1 -: 4];
    end else begin : g_prog_narrow
      assign hold_top = {hold_cnt, {(4-HW){1'b0}}};
    end
  endgenerate

  assign progress = (state_q == S_HOLD) ? hold_top : 4'd0;
  assign state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed test-plan steps plus a random soak, all checked every
// cycle against a time-since-restart reference model. Honours WATCHDOG_EN like the design.
module tb_reset_sequencer;

  localparam int HOLD   = 100;
  localparam int STAGE  = 4;
  localparam int NUM    = 3;
  localparam int DEB    = 8;
  localparam int WDT    = 50;
  localparam int T_RUN  = HOLD + (NUM - 1) * STAGE;
  localparam int ALL    = (1 << NUM) - 1;
  localparam int PSHIFT = $clog2(HOLD) - 4;

  logic           clock = 1'b0;
  logic           rst = 1'b1;
  logic           button_n = 1'b1;
  logic           clock_locked = 1'b1;
  logic           wdt_kick = 1'b0;
  logic [NUM-1:0] domain_rst;
  logic [1:0]     state;
  logic [1:0]     reset_cause;
  logic [3:0]     progress;

  reset_sequencer #(
    .FREQ(1_000_000),
    .HOLD_CYCLES(HOLD),
    .STAGE_CYCLES(STAGE),
    .NUM_DOMAINS(NUM),
    .DEBOUNCE_CYCLES(DEB),
    .WDT_CYCLES(WDT)
  ) dut (
    .clock(clock),
    .rst(rst),
    .button_n(button_n),
    .clock_locked(clock_locked),
    .wdt_kick(wdt_kick),
    .domain_rst(domain_rst),
    .state(state),
    .reset_cause(reset_cause),
    .progress(progress)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: t = edges since the last restart (0 means hold counter just reloaded).
  int   t_m       = 0;
  int   cause_m   = 0;
  bit   pressed_m = 1'b0;
  int   run_m     = 0;
  int   n_edge    = 0;
  int   last_load = 0;
  logic lq0 = 1'b1, lq1 = 1'b1, bq0 = 1'b1, bq1 = 1'b1;
  bit   auto_kick = 1'b1;
  int   kick_wait = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, n_edge);
    end
  endtask

  task automatic cycle();
    logic lock_seen, btn_seen;
    bit   in_run, f;
    int   c, k, e_dom, e_state, e_prog;
    @(posedge clock);
    n_edge++;
    lock_seen = lq1;
    btn_seen  = bq1;
    lq1 = lq0; lq0 = clock_locked;
    bq1 = bq0; bq0 = button_n;
    if (rst) begin
      t_m = 0; cause_m = 0; pressed_m = 1'b0; run_m = 0;
    end else begin
      in_run = (t_m >= T_RUN);
      f = 1'b0; c = 0;
      if (pressed_m) begin f = 1'b1; c = 1; end
      else if (!lock_seen) begin f = 1'b1; c = 2; end
`ifdef WATCHDOG_EN
      else if (in_run && !wdt_kick && (n_edge - last_load) >= WDT) begin f = 1'b1; c = 3; end
`endif
      if (f) begin
        t_m = 0; cause_m = c;
      end else begin
        if (in_run && wdt_kick) last_load = n_edge;
        if (t_m < T_RUN) begin
          t_m++;
          if (t_m == T_RUN) last_load = n_edge;
        end
      end
      if (bit'(!btn_seen) != pressed_m) begin
        run_m++;
        if (run_m == DEB) begin pressed_m = !btn_seen; run_m = 0; end
      end else begin
        run_m = 0;
      end
    end
    #1;
    if (t_m < HOLD) begin
      k = 0; e_state = 0; e_prog = (HOLD - 1 - t_m) >> PSHIFT;
    end else begin
      k = 1 + (t_m - HOLD) / STAGE;
      if (k > NUM) k = NUM;
      e_state = (k < NUM) ? 1 : 2;
      e_prog = 0;
    end
    e_dom = (ALL << k) & ALL;
    check("dom",   32'(domain_rst),  e_dom);
    check("state", 32'(state),       e_state);
    check("cause", 32'(reset_cause), cause_m);
    check("prog",  32'(progress),    e_prog);
    if (auto_kick) begin
      if (kick_wait == 0) begin
        wdt_kick = 1'b1;
        kick_wait = $urandom_range(0, 44);
      end else begin
        wdt_kick = 1'b0;
        kick_wait--;
      end
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int g, sel;
    // Power-up
    cycles(5);
    check("rst_dom",   32'(domain_rst),  7);
    check("rst_state", 32'(state),       0);
    check("rst_cause", 32'(reset_cause), 0);
    check("rst_prog",  32'(progress),    12);
    rst = 1'b0;
    cycles(99);
    check("pup_dom_99", 32'(domain_rst), 7);
    cycle();
    check("pup_dom_100", 32'(domain_rst), 6);
    cycles(4);
    check("pup_dom_104", 32'(domain_rst), 4);
    cycles(4);
    check("pup_dom_108", 32'(domain_rst), 0);
    check("pup_state",   32'(state),      2);
    check("pup_cause",   32'(reset_cause), 0);

    // Short glitch is filtered
    g = $urandom_range(1, DEB - 1);
    button_n = 1'b0;
    cycles(g);
    button_n = 1'b1;
    cycles(20);
    check("glitch_state", 32'(state), 2);

    // Long press restarts on the 11th edge
    button_n = 1'b0;
    cycles(10);
    check("press_10", 32'(domain_rst), 0);
    cycle();
    check("press_11_dom",   32'(domain_rst),  7);
    check("press_11_cause", 32'(reset_cause), 1);
    cycles(9);
    button_n = 1'b1;
    cycles(130);
    check("press_recover", 32'(state), 2);

    // Lock loss during RELEASE with domain_rst = 6
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycles(100);
    check("lock_pre", 32'(domain_rst), 6);
    clock_locked = 1'b0;
    cycle();
    clock_locked = 1'b1;
    cycle();
    check("lock_2", 32'(domain_rst), 6);
    cycle();
    check("lock_3_dom",   32'(domain_rst),  7);
    check("lock_3_cause", 32'(reset_cause), 2);
    cycles(99);
    check("lock_hold_99", 32'(domain_rst), 7);
    cycle();
    check("lock_hold_100", 32'(domain_rst), 6);
    cycles(20);

    // Button accepted and lock lost on the same edge
    button_n = 1'b0;
    cycles(8);
    clock_locked = 1'b0;
    cycle();
    clock_locked = 1'b1;
    cycle();
    check("sim_pre", 32'(domain_rst), 0);
    cycle();
    check("sim_dom",   32'(domain_rst),  7);
    check("sim_cause", 32'(reset_cause), 1);
    button_n = 1'b1;
    cycles(30);
    rst = 1'b1;
    cycle();
    check("rstmid_prog",  32'(progress),    12);
    check("rstmid_cause", 32'(reset_cause), 0);
    rst = 1'b0;
    cycles(120);
    check("rstmid_run", 32'(state), 2);

`ifdef WATCHDOG_EN
    auto_kick = 1'b0;
    for (int i = 0; i < 25; i++) begin
      wdt_kick = 1'b1;
      cycle();
      wdt_kick = 1'b0;
      cycles(39);
    end
    check("wdt_kept", 32'(state), 2);
    wdt_kick = 1'b1;
    cycle();
    wdt_kick = 1'b0;
    cycles(49);
    check("wdt_49", 32'(domain_rst), 0);
    cycle();
    check("wdt_50_dom",   32'(domain_rst),  7);
    check("wdt_50_cause", 32'(reset_cause), 3);
    auto_kick = 1'b1;
    kick_wait = 0;
    cycles(130);
`else
    auto_kick = 1'b0;
    wdt_kick = 1'b0;
    cycles(1000);
    check("nowdt_dom",   32'(domain_rst), 0);
    check("nowdt_state", 32'(state),      2);
    auto_kick = 1'b1;
`endif

    // Random soak
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: begin button_n = 1'b0; cycles($urandom_range(1, DEB - 1)); button_n = 1'b1; end
        1: begin button_n = 1'b0; cycles($urandom_range(10, 30)); button_n = 1'b1; end
        2: begin clock_locked = 1'b0; cycles($urandom_range(1, 4)); clock_locked = 1'b1; end
        3: cycles($urandom_range(1, 150));
        default: begin rst = 1'b1; cycle(); rst = 1'b0; end
      endcase
      cycles($urandom_range(0, 60));
    end
    cycles(150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
